// File: rtl/launch_pkg.sv
// Shared types and constants for the program launch controller.
// Holds the launch FSM state enum, resident program count and default entry addresses.
package launch_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, LAUNCH, RUN, DONE} launch_state_t;

  localparam int NUM_PROGS = 3;
  localparam logic [1:0] LAST_PROG = 2'(NUM_PROGS - 1);

  localparam logic [9:0] P0_BASE_DEF = 10'd0;
  localparam logic [9:0] P1_BASE_DEF = 10'd100;
  localparam logic [9:0] P2_BASE_DEF = 10'd300;

  function automatic logic [1:0] next_prog(input logic [1:0] sel);
    if (sel >= LAST_PROG) return 2'd0;
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// Saturating RUN-cycle counter with synchronous clear and enable.
// Raises terminal while the count equals TIMEOUT-1.
module run_watchdog #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  output logic             terminal,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) count_d = '0;
    else if (enable && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign terminal = (count_q == TC_VAL);
  assign count    = count_q;

endmodule

// File: rtl/program_launch_ctrl.sv
// Run controller: Start/Ack handshake, program selection, PC load, halt detect, watchdog.
// Optional macro LAUNCH_CYCLE_COUNT_EN enables the CycleCnt latch; otherwise CycleCnt is 0.
module program_launch_ctrl
  import launch_pkg::*;
#(
  parameter int              PC_W    = 10,
  parameter logic [PC_W-1:0] P0_BASE = PC_W'(P0_BASE_DEF),
  parameter logic [PC_W-1:0] P1_BASE = PC_W'(P1_BASE_DEF),
  parameter logic [PC_W-1:0] P2_BASE = PC_W'(P2_BASE_DEF),
  parameter int              TIMEOUT = 4096,
  parameter int              CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  output logic             Ack,
  output logic             Run,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcStart,
  output logic [1:0]       ProgSel,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCnt
);

  launch_state_t    state_q, state_d;
  logic [1:0]       prog_sel_q, prog_sel_d;
  logic             timeout_q, timeout_d;
  logic             ack_q, ack_d;
  logic             run_q, run_d;
  logic             pc_load_q, pc_load_d;
  logic             finish;
  logic             wd_clear, wd_enable, wd_terminal;
  logic [CNT_W-1:0] wd_count;

  run_watchdog #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_watchdog (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .terminal (wd_terminal),
    .count    (wd_count)
  );

  // Halt takes priority over the watchdog when both fire in the same RUN cycle.
  always_comb begin
    state_d    = state_q;
    prog_sel_d = prog_sel_q;
    timeout_d  = timeout_q;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: if (Start) state_d = ARMED;
      ARMED: begin
        wd_clear  = 1'b1;
        timeout_d = 1'b0;
        if (!Start) state_d = LAUNCH;
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        wd_enable = 1'b1;
        if (Halt) begin
          finish    = 1'b1;
          timeout_d = 1'b0;
        end else if (wd_terminal) begin
          finish    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      DONE: if (Start) state_d = ARMED;
      default: state_d = IDLE;
    endcase
    if (finish) begin
      state_d    = DONE;
      prog_sel_d = next_prog(prog_sel_q);
    end
    ack_d     = (state_d == DONE);
    run_d     = (state_d == RUN);
    pc_load_d = (state_d == LAUNCH);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      prog_sel_q <= 2'd0;
      timeout_q  <= 1'b0;
      ack_q      <= 1'b0;
      run_q      <= 1'b0;
      pc_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_sel_q <= prog_sel_d;
      timeout_q  <= timeout_d;
      ack_q      <= ack_d;
      run_q      <= run_d;
      pc_load_q  <= pc_load_d;
    end
  end

  always_comb begin
    PcStart = P0_BASE;
    case (prog_sel_q)
      2'd1:    PcStart = P1_BASE;
      2'd2:    PcStart = P2_BASE;
      default: PcStart = P0_BASE;
    endcase
  end

`ifdef LAUNCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  // The latched count includes the halting cycle itself.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (finish) cycle_cnt_d = (wd_count == '1) ? wd_count : wd_count + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cycle_cnt_q <= '0;
    else        cycle_cnt_q <= cycle_cnt_d;
  end

  assign CycleCnt = cycle_cnt_q;
`else
  logic unused_wd_count;
  assign unused_wd_count = ^wd_count;
  assign CycleCnt        = '0;
`endif

  assign Ack     = ack_q;
  assign Run     = run_q;
  assign PcLoad  = pc_load_q;
  assign ProgSel = prog_sel_q;
  assign Timeout = timeout_q;

endmodule
